// File: rtl/param_memory_bank.sv
// Parameterised register-file bank. It has a latency-1 registered read port and a
// write-first bypass, and a clear request sweeps the bank to zero one word per cycle.
module param_memory_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  input  logic             clr,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             rhit,
  output logic             busy
);

  localparam int unsigned DEPTH_U = DEPTH;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       mem_q [DEPTH];
  logic [WIDTH-1:0]       mem_d [DEPTH];
  logic [DEPTH-1:0]       flag_q, flag_d;
  logic [AW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]       rdata_q, rdata_d;
  logic                   rvalid_q, rvalid_d;
  logic                   rhit_q, rhit_d;

  logic wr_ok, rd_ok, sweep_last;

  assign wr_ok      = we && (32'(waddr) < DEPTH_U);
  assign rd_ok      = 32'(raddr) < DEPTH_U;
  assign sweep_last = (cnt_q == AW'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (clr) state_d = CLEAR;
      CLEAR: if (sweep_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == CLEAR);
  end

  // A clear request takes priority over a same-cycle write or read.
  always_comb begin
    mem_d    = mem_q;
    flag_d   = flag_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    rhit_d   = rhit_q;
    rvalid_d = 1'b0;
    if (state_q == IDLE) begin
      if (clr) begin
        cnt_d = '0;
      end else begin
        if (wr_ok) begin
          mem_d[waddr]  = wdata;
          flag_d[waddr] = 1'b1;
        end
        if (re) begin
          rvalid_d = 1'b1;
          if (!rd_ok) begin
            rdata_d = '0;
            rhit_d  = 1'b0;
          end else if (wr_ok && (waddr == raddr)) begin
            rdata_d = wdata;
            rhit_d  = 1'b1;
          end else begin
            rdata_d = mem_q[raddr];
            rhit_d  = flag_q[raddr];
          end
        end
      end
    end else begin
      mem_d[cnt_q]  = '0;
      flag_d[cnt_q] = 1'b0;
      if (!sweep_last) cnt_d = cnt_q + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH_U; i++) mem_q[i] <= '0;
      flag_q   <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rhit_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      flag_q   <= flag_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      rhit_q   <= rhit_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign rhit   = rhit_q;

endmodule

// File: tb/tb_param_memory_bank.sv
// Directed bench for param_memory_bank: default 8x4 instance plus a 16x5 instance.
module tb_param_memory_bank;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Instance A: WIDTH=8, DEPTH=4
  logic       a_we, a_re, a_clr;
  logic [1:0] a_waddr, a_raddr;
  logic [7:0] a_wdata, a_rdata;
  logic       a_rvalid, a_rhit, a_busy;

  param_memory_bank #(.WIDTH(8), .DEPTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .we(a_we), .waddr(a_waddr), .wdata(a_wdata),
    .re(a_re), .raddr(a_raddr), .clr(a_clr), .rdata(a_rdata),
    .rvalid(a_rvalid), .rhit(a_rhit), .busy(a_busy)
  );

  // Instance B: WIDTH=16, DEPTH=5
  logic        b_we, b_re, b_clr;
  logic [2:0]  b_waddr, b_raddr;
  logic [15:0] b_wdata, b_rdata;
  logic        b_rvalid, b_rhit, b_busy;

  param_memory_bank #(.WIDTH(16), .DEPTH(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .we(b_we), .waddr(b_waddr), .wdata(b_wdata),
    .re(b_re), .raddr(b_raddr), .clr(b_clr), .rdata(b_rdata),
    .rvalid(b_rvalid), .rhit(b_rhit), .busy(b_busy)
  );

  typedef struct {
    logic       we;
    logic [1:0] waddr;
    logic [7:0] wdata;
    logic       re;
    logic [1:0] raddr;
    logic       clr;
    logic       rvalid;
    logic [7:0] rdata;
    logic       rhit;
    logic       busy;
  } vec_t;

  vec_t vt [10];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_a(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                         input logic re, input logic [1:0] ra, input logic clr);
    @(negedge clk);
    a_we = we; a_waddr = wa; a_wdata = wd; a_re = re; a_raddr = ra; a_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic we, input logic [2:0] wa, input logic [15:0] wd,
                         input logic re, input logic [2:0] ra, input logic clr);
    @(negedge clk);
    b_we = we; b_waddr = wa; b_wdata = wd; b_re = re; b_raddr = ra; b_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic read_a(input logic [1:0] ra, input logic [7:0] exp_d, input logic exp_h,
                        input string name);
    drive_a(1'b0, 2'd0, 8'h00, 1'b1, ra, 1'b0);
    chk({name, ".rvalid"}, 32'(a_rvalid), 32'd1);
    chk({name, ".rdata"},  32'(a_rdata),  32'(exp_d));
    chk({name, ".rhit"},   32'(a_rhit),   32'(exp_h));
  endtask

  initial begin
    // we  wa  wdata re  ra  clr | rvalid rdata rhit busy
    vt[0] = '{1'b1, 2'd2, 8'hA5, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[1] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0};
    vt[2] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vt[3] = '{1'b1, 2'd3, 8'h3C, 1'b1, 2'd3, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b0};
    vt[4] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
    vt[5] = '{1'b1, 2'd0, 8'h11, 1'b0, 2'd0, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0};
    vt[6] = '{1'b1, 2'd1, 8'h22, 1'b1, 2'd2, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0};
    vt[7] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0};
    vt[8] = '{1'b1, 2'd1, 8'h5A, 1'b1, 2'd0, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0};
    vt[9] = '{1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0};

    a_we = 0; a_waddr = 0; a_wdata = 0; a_re = 0; a_raddr = 0; a_clr = 0;
    b_we = 0; b_waddr = 0; b_wdata = 0; b_re = 0; b_raddr = 0; b_clr = 0;
    rst_n = 1'b0;
    #1;
    chk("reset.rdata",  32'(a_rdata),  32'd0);
    chk("reset.rvalid", 32'(a_rvalid), 32'd0);
    chk("reset.rhit",   32'(a_rhit),   32'd0);
    chk("reset.busy",   32'(a_busy),   32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      drive_a(vt[i].we, vt[i].waddr, vt[i].wdata, vt[i].re, vt[i].raddr, vt[i].clr);
      chk($sformatf("vec%0d.rvalid", i), 32'(a_rvalid), 32'(vt[i].rvalid));
      chk($sformatf("vec%0d.rdata", i),  32'(a_rdata),  32'(vt[i].rdata));
      chk($sformatf("vec%0d.busy", i),   32'(a_busy),   32'(vt[i].busy));
      if (vt[i].rvalid) chk($sformatf("vec%0d.rhit", i), 32'(a_rhit), 32'(vt[i].rhit));
    end

    // clr together with write to addr 0 and read: clr wins, busy for exactly 4 cycles
    drive_a(1'b1, 2'd0, 8'h77, 1'b1, 2'd0, 1'b1);
    chk("clr.rvalid", 32'(a_rvalid), 32'd0);
    chk("clr.busy0",  32'(a_busy),   32'd1);
    for (int k = 1; k < 5; k++) begin
      drive_a(1'b1, 2'd1, 8'hFF, 1'b1, 2'd1, 1'b1);
      chk($sformatf("sweep%0d.busy", k),   32'(a_busy),   32'(k < 4));
      chk($sformatf("sweep%0d.rvalid", k), 32'(a_rvalid), 32'd0);
    end
    for (int i = 0; i < 4; i++) read_a(2'(i), 8'h00, 1'b0, $sformatf("postclr%0d", i));

    // async reset during the second sweep cycle
    drive_a(1'b1, 2'd2, 8'hC3, 1'b0, 2'd0, 1'b0);
    read_a(2'd2, 8'hC3, 1'b1, "prerst");
    drive_a(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1);
    drive_a(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b0);
    chk("midsweep.busy_before", 32'(a_busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst.busy",   32'(a_busy),   32'd0);
    chk("rst.rvalid", 32'(a_rvalid), 32'd0);
    chk("rst.rdata",  32'(a_rdata),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) read_a(2'(i), 8'h00, 1'b0, $sformatf("postrst%0d", i));
    drive_a(1'b1, 2'd1, 8'h9E, 1'b1, 2'd1, 1'b0);
    chk("postrst.bypass", 32'(a_rdata), 32'h9E);

    // DEPTH=5 instance: out-of-range address and 5-cycle sweep
    drive_b(1'b1, 3'd6, 16'hBEEF, 1'b0, 3'd0, 1'b0);
    drive_b(1'b1, 3'd4, 16'h1234, 1'b1, 3'd6, 1'b0);
    chk("b.oor.rvalid", 32'(b_rvalid), 32'd1);
    chk("b.oor.rdata",  32'(b_rdata),  32'd0);
    chk("b.oor.rhit",   32'(b_rhit),   32'd0);
    drive_b(1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 1'b0);
    chk("b.w4.rdata", 32'(b_rdata), 32'h1234);
    chk("b.w4.rhit",  32'(b_rhit),  32'd1);
    drive_b(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b1);
    chk("b.clr.busy0", 32'(b_busy), 32'd1);
    for (int k = 1; k < 6; k++) begin
      drive_b(1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 1'b0);
      chk($sformatf("b.sweep%0d.busy", k), 32'(b_busy), 32'(k < 5));
    end
    drive_b(1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 1'b0);
    chk("b.postclr.rdata", 32'(b_rdata), 32'd0);
    chk("b.postclr.rhit",  32'(b_rhit),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/param_memory_bank.md
PARAM_MEMORY_BANK -- requirements
Module: param_memory_bank

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 SHALL have parameter WIDTH, default 8, bits per word (WIDTH >= 1).
REQ-003 SHALL have parameter DEPTH, default 4, number of words (DEPTH >= 2; need not be a power of 2).
REQ-004 SHALL derive AW = max(1, ceil(log2(DEPTH))) as the address width.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port we  input  1  write enable.
REQ-008 SHALL have port waddr  input  AW  write address.
REQ-009 SHALL have port wdata  input  WIDTH  write data.
REQ-010 SHALL have port re  input  1  read request.
REQ-011 SHALL have port raddr  input  AW  read address.
REQ-012 SHALL have port clr  input  1  single-cycle request to clear all words.
REQ-013 SHALL have port rdata  output  WIDTH  registered read data.
REQ-014 SHALL have port rvalid  output  1  rdata is valid this cycle.
REQ-015 SHALL have port rhit  output  1  the word read was written since the last reset or clear.
REQ-016 SHALL have port busy  output  1  a clear sweep is in progress.

Function
REQ-017 SHALL hold DEPTH words of WIDTH bits, plus one written-flag per word, all in clocked registers (no latches).
REQ-018 SHALL implement a two-state FSM: IDLE and CLEAR.
REQ-019 In IDLE, when we=1 and waddr < DEPTH, SHALL store wdata at waddr and set its written-flag at the same clock edge.
REQ-020 SHALL ignore a write with waddr >= DEPTH, leaving storage and flags unchanged.
REQ-021 In IDLE, when re=1, SHALL drive rdata and rhit on the next cycle with rvalid=1 for exactly that cycle (latency 1).
REQ-022 For re with raddr >= DEPTH, SHALL return rdata=0, rhit=0, rvalid=1.
REQ-023 On same-cycle read and write to the same valid address, SHALL return the new wdata with rhit=1 (write-first bypass).
REQ-024 When re=0, or while in CLEAR, SHALL drive rvalid=0 next cycle and hold rdata at its last value.
REQ-025 In IDLE, clr=1 SHALL move the FSM to CLEAR and assert busy from the next cycle.
REQ-026 If clr, we and re are asserted in the same IDLE cycle, clr SHALL win: the write is dropped and the read produces rvalid=0.
REQ-027 In CLEAR, SHALL zero one word and its flag per cycle, in order address 0 to DEPTH-1, using an internal AW-bit sweep counter.
REQ-028 Busy SHALL stay high for exactly DEPTH cycles; after clearing word DEPTH-1, the FSM SHALL return to IDLE with busy=0 in the following cycle.
REQ-029 In CLEAR, SHALL ignore we, re and clr; a clr arriving during CLEAR does not restart or extend the sweep.
REQ-030 The sweep counter SHALL end at DEPTH-1, never wrap past it, and reset to 0 on entry to CLEAR.

Reset
REQ-031 When rst_n=0, SHALL immediately, without waiting for clk, set all words to 0, all flags to 0, rdata=0, rvalid=0, rhit=0, busy=0, the FSM to IDLE and the sweep counter to 0.
REQ-032 Reset asserted mid-sweep SHALL abort the sweep; after release the block SHALL be in IDLE.
REQ-033 On the first rising edge after rst_n rises, SHALL accept we, re and clr normally.

Verification (WIDTH=8, DEPTH=4 unless stated)
REQ-034 Write 0xA5 to addr 2, then read addr 2 next cycle -> one cycle later: rdata=0xA5, rvalid=1, rhit=1; reading addr 1 -> rdata=0x00, rhit=0.
REQ-035 Same-cycle we=1 waddr=3 wdata=0x3C with re=1 raddr=3 -> next cycle rdata=0x3C, rhit=1, rvalid=1.
REQ-036 Fill all 4 words, pulse clr -> busy=1 for exactly 4 cycles; a we during busy is ignored; then reading each address -> rdata=0x00, rhit=0.
REQ-037 Same-cycle clr=1 with we=1 to addr 0 -> after the sweep, addr 0 reads 0x00 with rhit=0.
REQ-038 Assert rst_n=0 asynchronously during the 2nd sweep cycle -> busy=0 and rvalid=0 immediately; after release, all reads return 0x00 with rhit=0.
REQ-039 With DEPTH=5, WIDTH=16: a write to addr 6 is ignored; a read of addr 6 -> rdata=0, rhit=0, rvalid=1; clr -> busy=1 for 5 cycles.
